// File: rtl/day10_button_search_ctrl.sv
// ============================================================================
//  Module   : day10_button_search_ctrl
//  Brief    : Walks every button subset in Gray order, one XOR per cycle, and
//             reports the minimum press count whose XOR equals the target.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module day10_button_search_ctrl #(
    parameter int MAX_NUM_LIGHTS  = 16,
    parameter int MAX_NUM_BUTTONS = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    output logic                                        start_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]                   target,
    input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0]   buttons,
    input  logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]        num_buttons,
    output logic                                        result_valid,
    input  logic                                        result_ready,
    output logic                                        result_found,
    output logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]        result_presses
);

    localparam int NB_W  = $clog2(MAX_NUM_BUTTONS + 1);
    localparam int IDX_W = (MAX_NUM_BUTTONS > 1) ? $clog2(MAX_NUM_BUTTONS) : 1;
    localparam int K_W   = MAX_NUM_BUTTONS + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [MAX_NUM_LIGHTS-1:0]   target_q, target_d;
    logic [MAX_NUM_LIGHTS-1:0]   btn_q [MAX_NUM_BUTTONS];
    logic [MAX_NUM_LIGHTS-1:0]   btn_d [MAX_NUM_BUTTONS];
    logic [NB_W-1:0]             n_q, n_d;
    logic [MAX_NUM_LIGHTS-1:0]   acc_q, acc_d;
    logic [MAX_NUM_BUTTONS-1:0]  gray_q, gray_d;
    logic [K_W-1:0]              k_q, k_d;
    logic [NB_W-1:0]             cnt_q, cnt_d;
    logic [NB_W-1:0]             best_q, best_d;
    logic                        found_q, found_d;
    logic                        start_ready_q, start_ready_d;
    logic                        result_valid_q, result_valid_d;
    logic                        result_found_q, result_found_d;
    logic [NB_W-1:0]             result_presses_q, result_presses_d;

    logic [K_W-1:0]              w_last;
    logic [K_W-1:0]              w_k_inc;
    logic [IDX_W-1:0]            w_idx;
    logic [NB_W-1:0]             w_n_clamped;

    // Index of the lowest set bit; the Gray code flips exactly this button.
    function automatic logic [IDX_W-1:0] ctz(input logic [MAX_NUM_BUTTONS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int b = MAX_NUM_BUTTONS - 1; b >= 0; b--) begin
            if (v[b]) r = IDX_W'(b);
        end
        return r;
    endfunction

    assign w_last      = (K_W'(1) << n_q) - K_W'(1);
    assign w_k_inc     = k_q + K_W'(1);
    assign w_idx       = ctz(w_k_inc[MAX_NUM_BUTTONS-1:0]);
    assign w_n_clamped = (num_buttons > NB_W'(MAX_NUM_BUTTONS)) ? NB_W'(MAX_NUM_BUTTONS)
                                                                : num_buttons;

    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        btn_d            = btn_q;
        n_d              = n_q;
        acc_d            = acc_q;
        gray_d           = gray_q;
        k_d              = k_q;
        cnt_d            = cnt_q;
        best_d           = best_q;
        found_d          = found_q;
        start_ready_d    = start_ready_q;
        result_valid_d   = result_valid_q;
        result_found_d   = result_found_q;
        result_presses_d = result_presses_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d = target;
                    for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
                        btn_d[b] = buttons[b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS];
                    end
                    n_d           = w_n_clamped;
                    acc_d         = '0;
                    gray_d        = '0;
                    k_d           = '0;
                    cnt_d         = '0;
                    best_d        = '1;
                    found_d       = 1'b0;
                    start_ready_d = 1'b0;
                    state_d       = ST_SEARCH;
                end
            end

            ST_SEARCH: begin
                if ((acc_q == target_q) && (cnt_q < best_q)) begin
                    best_d  = cnt_q;
                    found_d = 1'b1;
                end
                if (k_q == w_last) begin
                    state_d = ST_DONE;
                end else begin
                    k_d           = w_k_inc;
                    acc_d         = acc_q ^ btn_q[w_idx];
                    gray_d[w_idx] = ~gray_q[w_idx];
                    cnt_d         = gray_q[w_idx] ? (cnt_q - NB_W'(1)) : (cnt_q + NB_W'(1));
                end
            end

            ST_DONE: begin
                result_valid_d   = 1'b1;
                result_found_d   = found_q;
                result_presses_d = found_q ? best_q : '0;
                // Handshake completes on the registered valid, so start is not seen here.
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    start_ready_d  = 1'b1;
                    state_d        = ST_IDLE;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                start_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            target_q         <= '0;
            for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
                btn_q[b] <= '0;
            end
            n_q              <= '0;
            acc_q            <= '0;
            gray_q           <= '0;
            k_q              <= '0;
            cnt_q            <= '0;
            best_q           <= '1;
            found_q          <= 1'b0;
            start_ready_q    <= 1'b1;
            result_valid_q   <= 1'b0;
            result_found_q   <= 1'b0;
            result_presses_q <= '0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            btn_q            <= btn_d;
            n_q              <= n_d;
            acc_q            <= acc_d;
            gray_q           <= gray_d;
            k_q              <= k_d;
            cnt_q            <= cnt_d;
            best_q           <= best_d;
            found_q          <= found_d;
            start_ready_q    <= start_ready_d;
            result_valid_q   <= result_valid_d;
            result_found_q   <= result_found_d;
            result_presses_q <= result_presses_d;
        end
    end

    assign start_ready    = start_ready_q;
    assign result_valid   = result_valid_q;
    assign result_found   = result_found_q;
    assign result_presses = result_presses_q;

endmodule

`default_nettype wire
